// File: rtl/flag_context_ctrl.sv
// flag_context_ctrl: saves the flag word on exception entry and restores it on return.
// Latency: entry ack/load 2 edges after the request is sampled, return and fault loads 1 edge after.
// Backpressure: 4-phase req/ack; new requests are accepted only in IDLE, and in WAIT_REL until both requests drop.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   flags_in     current flag register contents {NEG, ZER, CAR, OVERF, MODE}
//   enter_req    exception entry request (level, held until enter_ack)
//   return_req   exception return request (level, held until return_ack)
//   clear_fault  pulse that leaves FAULT and discards every saved context
//   enter_ack    pulse: entry complete
//   return_ack   pulse: return complete
//   flags_load   pulse: flag register captures flags_out on the next edge
//   flags_out    value for the flag register
//   depth        number of saved contexts
//   full/empty   depth==DEPTH / depth==0 (combinational)
//   fault        high while the sequencer sits in FAULT
module flag_context_ctrl #(
  parameter int DEPTH = 4,
  parameter int FW    = 5,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [FW-1:0] flags_in,
  input  logic          enter_req,
  input  logic          return_req,
  input  logic          clear_fault,
  output logic          enter_ack,
  output logic          return_ack,
  output logic          flags_load,
  output logic [FW-1:0] flags_out,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE     = 3'd1,
    SWITCH   = 3'd2,
    RESTORE  = 3'd3,
    WAIT_REL = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [FW-1:0] flags_out_q, flags_out_d;
  logic          flags_load_q, flags_load_d;
  logic          enter_ack_q, enter_ack_d;
  logic          return_ack_q, return_ack_d;
  logic          fault_q, fault_d;
  // Marks the first cycle in FAULT so the halt pattern is loaded exactly once.
  logic          fault_new_q, fault_new_d;

  logic [FW-1:0] lifo_q [DEPTH];
  logic          push_en;
  logic [DW-1:0] depth_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign depth_m1 = depth_q - DW'(1);
  // SAVE is only reachable with depth<DEPTH and RESTORE with depth>0,
  // so both indices always land inside the array.
  assign wr_idx   = depth_q[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    flags_out_d  = flags_out_q;
    flags_load_d = 1'b0;
    enter_ack_d  = 1'b0;
    return_ack_d = 1'b0;
    fault_new_d  = 1'b0;
    push_en      = 1'b0;

    case (state_q)
      IDLE: begin
        // Entry wins over return; overflow/underflow leave depth untouched.
        if (enter_req) begin
          if (full) begin
            state_d     = FAULT;
            fault_new_d = 1'b1;
          end else begin
            state_d = SAVE;
          end
        end else if (return_req) begin
          if (empty) begin
            state_d     = FAULT;
            fault_new_d = 1'b1;
          end else begin
            state_d = RESTORE;
          end
        end
      end

      SAVE: begin
        push_en = 1'b1;
        depth_d = depth_q + DW'(1);
        state_d = SWITCH;
      end

      SWITCH: begin
        // Only MODE is forced to supervisor; N/Z/C/V pass through.
        flags_out_d  = {flags_in[FW-1:1], 1'b1};
        flags_load_d = 1'b1;
        enter_ack_d  = 1'b1;
        state_d      = WAIT_REL;
      end

      RESTORE: begin
        flags_out_d  = lifo_q[rd_idx];
        depth_d      = depth_m1;
        flags_load_d = 1'b1;
        return_ack_d = 1'b1;
        state_d      = WAIT_REL;
      end

      WAIT_REL: begin
        if (!enter_req && !return_req) begin
          state_d = IDLE;
        end
      end

      FAULT: begin
        if (fault_new_q) begin
          flags_out_d  = {FW{1'b1}};
          flags_load_d = 1'b1;
        end
        if (clear_fault) begin
          depth_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      depth_q      <= '0;
      flags_out_q  <= '0;
      flags_load_q <= 1'b0;
      enter_ack_q  <= 1'b0;
      return_ack_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_new_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      flags_out_q  <= flags_out_d;
      flags_load_q <= flags_load_d;
      enter_ack_q  <= enter_ack_d;
      return_ack_q <= return_ack_d;
      fault_q      <= fault_d;
      fault_new_q  <= fault_new_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        lifo_q[i] <= '0;
      end
    end else if (push_en) begin
      lifo_q[wr_idx] <= flags_in;
    end
  end

  assign enter_ack  = enter_ack_q;
  assign return_ack = return_ack_q;
  assign flags_load = flags_load_q;
  assign flags_out  = flags_out_q;
  assign depth      = depth_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_flag_context_ctrl.sv
// tb_flag_context_ctrl: directed bench with an expected-load scoreboard for flag_context_ctrl.
// Latency: expected load events carry the edge count from request to flags_load.
// Backpressure: requests are held until the load/ack is seen, then dropped (4-phase).
module tb_flag_context_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] flags_in;
  logic       enter_req;
  logic       return_req;
  logic       clear_fault;
  logic       enter_ack;
  logic       return_ack;
  logic       flags_load;
  logic [4:0] flags_out;
  logic [2:0] depth;
  logic       full;
  logic       empty;
  logic       fault;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] flags;
    logic       eack;
    logic       rack;
    logic [2:0] depth;
    logic       fault;
    int         lat;
  } exp_t;

  exp_t sb[$];

  flag_context_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .flags_in    (flags_in),
    .enter_req   (enter_req),
    .return_req  (return_req),
    .clear_fault (clear_fault),
    .enter_ack   (enter_ack),
    .return_ack  (return_ack),
    .flags_load  (flags_load),
    .flags_out   (flags_out),
    .depth       (depth),
    .full        (full),
    .empty       (empty),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] f, input logic ea, input logic ra,
                          input logic [2:0] d, input logic flt, input int lat);
    exp_t e;
    e.flags = f;
    e.eack  = ea;
    e.rack  = ra;
    e.depth = d;
    e.fault = flt;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next flags_load pulse and compares it with the
  // oldest scoreboard entry. A timeout shows up as a latency mismatch.
  task automatic expect_load(input string tag);
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (flags_load !== 1'b1 && n < 20);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_lat"},   32'(n),          32'(e.lat));
      check({tag, "_load"},  32'(flags_load), 32'd1);
      check({tag, "_flags"}, 32'(flags_out),  32'(e.flags));
      check({tag, "_eack"},  32'(enter_ack),  32'(e.eack));
      check({tag, "_rack"},  32'(return_ack), 32'(e.rack));
      check({tag, "_depth"}, 32'(depth),      32'(e.depth));
      check({tag, "_fault"}, 32'(fault),      32'(e.fault));
    end
  endtask

  task automatic do_enter(input string tag, input logic [4:0] f, input logic [2:0] d);
    logic [4:0] ef;
    ef = {f[4:1], 1'b1};
    flags_in  = f;
    enter_req = 1'b1;
    push_exp(ef, 1'b1, 1'b0, d, 1'b0, 3);
    expect_load(tag);
    enter_req = 1'b0;
    @(negedge clock);
    check({tag, "_load_pulse"}, 32'(flags_load), 32'd0);
    check({tag, "_eack_pulse"}, 32'(enter_ack),  32'd0);
  endtask

  task automatic do_return(input string tag, input logic [4:0] ef, input logic [2:0] d);
    return_req = 1'b1;
    push_exp(ef, 1'b0, 1'b1, d, 1'b0, 2);
    expect_load(tag);
    return_req = 1'b0;
    @(negedge clock);
    check({tag, "_load_pulse"}, 32'(flags_load), 32'd0);
    check({tag, "_rack_pulse"}, 32'(return_ack), 32'd0);
  endtask

  task automatic do_fault(input string tag, input logic is_enter, input logic [2:0] d);
    if (is_enter) enter_req = 1'b1;
    else          return_req = 1'b1;
    push_exp(5'h1f, 1'b0, 1'b0, d, 1'b1, 2);
    expect_load(tag);
    enter_req  = 1'b0;
    return_req = 1'b0;
    @(negedge clock);
    check({tag, "_load_once"}, 32'(flags_load), 32'd0);
    check({tag, "_hold"},      32'(fault),      32'd1);
    check({tag, "_depth_kept"}, 32'(depth),     32'(d));
    repeat (2) @(negedge clock);
    check({tag, "_still"},  32'(fault), 32'd1);
    check({tag, "_no_ack"}, 32'({enter_ack, return_ack, flags_load}), 32'd0);
    clear_fault = 1'b1;
    @(negedge clock);
    clear_fault = 1'b0;
    check({tag, "_cleared"},   32'(fault), 32'd0);
    check({tag, "_depth_clr"}, 32'(depth), 32'd0);
    check({tag, "_empty"},     32'(empty), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    flags_in    = '0;
    enter_req   = 1'b0;
    return_req  = 1'b0;
    clear_fault = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_state", 32'({flags_out, flags_load, enter_ack, return_ack, fault, depth}), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single entry then return.
    do_enter("enter1", 5'b10100, 3'd1);
    check("enter1_empty", 32'(empty), 32'd0);
    flags_in = 5'b01011;
    do_return("return1", 5'b10100, 3'd0);
    check("return1_empty", 32'(empty), 32'd1);

    // Nested contexts come back in LIFO order.
    do_enter("nest_e1", 5'h10, 3'd1);
    do_enter("nest_e2", 5'h08, 3'd2);
    do_enter("nest_e3", 5'h04, 3'd3);
    do_return("nest_r1", 5'h04, 3'd2);
    do_return("nest_r2", 5'h08, 3'd1);
    do_return("nest_r3", 5'h10, 3'd0);

    // Overflow.
    do_enter("fill1", 5'h11, 3'd1);
    do_enter("fill2", 5'h12, 3'd2);
    do_enter("fill3", 5'h13, 3'd3);
    do_enter("fill4", 5'h14, 3'd4);
    check("fill_full", 32'(full), 32'd1);
    flags_in = 5'h00;
    do_fault("overflow", 1'b1, 3'd4);

    // Underflow.
    do_fault("underflow", 1'b0, 3'd0);

    // clear_fault outside FAULT has no effect.
    do_enter("pre_both", 5'h0a, 3'd1);
    clear_fault = 1'b1;
    @(negedge clock);
    clear_fault = 1'b0;
    check("stray_clear_depth", 32'(depth), 32'd1);

    // Simultaneous requests: entry is served, return waits for release.
    flags_in   = 5'h06;
    enter_req  = 1'b1;
    return_req = 1'b1;
    push_exp(5'h07, 1'b1, 1'b0, 3'd2, 1'b0, 3);
    expect_load("both");
    enter_req = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("both_no_ret", 32'({return_ack, flags_load}), 32'd0);
      check("both_depth",  32'(depth), 32'd2);
    end
    return_req = 1'b0;
    @(negedge clock);
    check("both_idle_depth", 32'(depth), 32'd2);

    // Reset during SWITCH aborts the entry.
    flags_in  = 5'h12;
    enter_req = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_outs", 32'({flags_out, flags_load, enter_ack, return_ack, fault}), 32'd0);
    check("midrst_depth", 32'(depth), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    @(negedge clock);
    check("midrst_no_ack", 32'({enter_ack, flags_load}), 32'd0);
    reset = 1'b1;
    push_exp(5'h13, 1'b1, 1'b0, 3'd1, 1'b0, 3);
    expect_load("post_rst");
    enter_req = 1'b0;
    @(negedge clock);
    check("post_rst_pulse", 32'(flags_load), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
